// File: rtl/spi_pkg.sv
// Shared types and helpers for the system-clocked SPI sample slave.
package spi_pkg;

    localparam int DEF_WORD_W   = 32;
    localparam int DEF_SAMPLE_W = 10;
    localparam int DEF_CH_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Channel id sits directly above the sample bits of a received word.
    function automatic int unsigned ch_field(input logic [63:0] word,
                                             input int          sample_w,
                                             input int          ch_w);
        logic [63:0] mask;
        mask = (64'd1 << ch_w) - 64'd1;
        return 32'((word >> sample_w) & mask);
    endfunction

endpackage

// File: rtl/spi_sample_slave_if.sv
// SPI pin bundle between the ADC/MCU master and the sample slave.
interface spi_sample_slave_if;

    logic sck;
    logic sdo;
    logic cs_n;
    logic sdi;

    modport master (
        output sck,
        output sdo,
        output cs_n,
        input  sdi
    );

    modport slave (
        input  sck,
        input  sdo,
        input  cs_n,
        output sdi
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle
// rise/fall strobes taken against a one-cycle delayed copy of the level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_p0;
    logic                   level_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_p0 <= {SYNC_STAGES{RESET_VAL}};
            level_p1 <= RESET_VAL;
        end else begin
            chain_p0 <= {chain_p0[SYNC_STAGES-2:0], din};
            // edge-detect stage: previous synchronised level
            level_p1 <= chain_p0[SYNC_STAGES-1];
        end
    end

    assign level = chain_p0[SYNC_STAGES-1];
    assign rise  = level & ~level_p1;
    assign fall  = ~level & level_p1;

endmodule

// File: rtl/spi_sample_slave.sv
// Mode-0 SPI slave oversampled on the system clock; latches the latest
// sample per channel for the FIR bank and streams tx_data back on sdi.
module spi_sample_slave
    import spi_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = DEF_CH_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    spi_sample_slave_if.slave          spi,
    input  logic [WORD_W-1:0]          tx_data,
    output logic                       tx_taken,
    output logic [WORD_W-1:0]          rx_data,
    output logic                       rx_valid,
    output logic [NUM_CH*SAMPLE_W-1:0] samples,
    output logic [NUM_CH-1:0]          sample_valid,
    output logic                       frame_err,
    output logic                       bad_ch,
    output logic [7:0]                 err_cnt
);

    localparam int                CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORD_W - 1);

    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic sdo_s;

    logic [SYNC_STAGES-1:0] sdo_chain;

    state_t state;
    state_t state_nxt;

    logic load_tx;
    logic shift_rx;
    logic shift_tx;
    logic finish;
    logic abort;
    logic go_idle;

    logic [WORD_W-1:0] tx_sr;
    logic [WORD_W-1:0] rx_sr;
    logic [CNT_W-1:0]  cnt;
    logic              sdi_en;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] samples_q;

    int unsigned ch_id;
    logic        ch_ok;
    logic        err_event;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi.sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi.cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // sdo is delayed exactly like sck so it is sampled at the synchronised rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdo_chain <= '0;
        end else begin
            sdo_chain <= {sdo_chain[SYNC_STAGES-2:0], spi.sdo};
        end
    end

    assign sdo_s = sdo_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else if (sck_rise && (cnt == LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = cs_level ? IDLE : SHIFT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The trailing sck fall of a word arrives after the DONE reload with the
    // counter back at 0; gating on cnt keeps it from eating the new MSB.
    always_comb begin
        load_tx  = 1'b0;
        shift_rx = 1'b0;
        shift_tx = 1'b0;
        finish   = 1'b0;
        abort    = 1'b0;
        go_idle  = 1'b0;
        unique case (state)
            IDLE: begin
                load_tx = cs_fall;
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort   = (cnt != '0);
                    go_idle = 1'b1;
                end else begin
                    shift_rx = sck_rise;
                    shift_tx = sck_fall && (cnt != '0);
                end
            end
            DONE: begin
                finish  = 1'b1;
                load_tx = ~cs_level;
                go_idle = cs_level;
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    assign ch_id     = ch_field(64'(rx_sr), SAMPLE_W, CH_W);
    assign ch_ok     = (ch_id < 32'(NUM_CH));
    assign err_event = (finish && !ch_ok) || abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr        <= '0;
            rx_sr        <= '0;
            cnt          <= '0;
            sdi_en       <= 1'b0;
            tx_taken     <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            samples_q    <= '0;
            sample_valid <= '0;
            frame_err    <= 1'b0;
            bad_ch       <= 1'b0;
            err_cnt      <= '0;
        end else begin
            tx_taken     <= 1'b0;
            rx_valid     <= 1'b0;
            sample_valid <= '0;
            frame_err    <= 1'b0;
            bad_ch       <= 1'b0;

            if (load_tx) begin
                tx_sr    <= tx_data;
                tx_taken <= 1'b1;
                cnt      <= '0;
                sdi_en   <= 1'b1;
            end else if (shift_tx) begin
                tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
            end else if (go_idle) begin
                sdi_en <= 1'b0;
            end

            if (shift_rx) begin
                rx_sr <= {rx_sr[WORD_W-2:0], sdo_s};
                cnt   <= cnt + 1'b1;
            end

            if (finish) begin
                rx_data  <= rx_sr;
                rx_valid <= 1'b1;
                bad_ch   <= ~ch_ok;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_ok && (ch_id == unsigned'(k))) begin
                        samples_q[k]    <= rx_sr[SAMPLE_W-1:0];
                        sample_valid[k] <= 1'b1;
                    end
                end
            end

            if (abort) begin
                frame_err <= 1'b1;
            end

            if (err_event && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign samples = samples_q;
    assign spi.sdi = sdi_en & tx_sr[WORD_W-1];

endmodule

// File: tb/tb_spi_sample_slave.sv
// Randomised bench for spi_sample_slave against a word-level reference model.
module tb_spi_sample_slave;

    localparam int WORD_W      = 32;
    localparam int SAMPLE_W    = 10;
    localparam int NUM_CH      = 4;
    localparam int CH_W        = 4;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset;
    logic [WORD_W-1:0]          tx_data;
    logic                       tx_taken;
    logic [WORD_W-1:0]          rx_data;
    logic                       rx_valid;
    logic [NUM_CH*SAMPLE_W-1:0] samples;
    logic [NUM_CH-1:0]          sample_valid;
    logic                       frame_err;
    logic                       bad_ch;
    logic [7:0]                 err_cnt;

    spi_sample_slave_if spi();

    spi_sample_slave #(
        .WORD_W      (WORD_W),
        .SAMPLE_W    (SAMPLE_W),
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .tx_data      (tx_data),
        .tx_taken     (tx_taken),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .samples      (samples),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .bad_ch       (bad_ch),
        .err_cnt      (err_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int half   = 5;

    // pulse counters observed on the falling edge
    int                n_rxv  = 0;
    int                n_txt  = 0;
    int                n_ferr = 0;
    int                n_bad  = 0;
    int                n_sv   = 0;
    logic [NUM_CH-1:0] sv_last = '0;

    always @(negedge clk) begin
        if (rx_valid)  n_rxv  <= n_rxv + 1;
        if (tx_taken)  n_txt  <= n_txt + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (bad_ch)    n_bad  <= n_bad + 1;
        if (sample_valid != '0) begin
            n_sv    <= n_sv + 1;
            sv_last <= sample_valid;
        end
    end

    // reference model state
    logic [31:0] m_rx;
    logic [9:0]  m_s [NUM_CH];
    int          m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_rx  = '0;
        m_err = 0;
        for (int k = 0; k < NUM_CH; k++) m_s[k] = '0;
    endfunction

    // Returns the expected sample_valid vector for a completed word.
    function automatic int model_word(input logic [31:0] w);
        int ch;
        m_rx = w;
        ch   = int'(w / 32'd1024) % 16;
        if (ch < NUM_CH) begin
            m_s[ch] = 10'(w % 32'd1024);
            return 1 << ch;
        end
        if (m_err < 255) m_err++;
        return 0;
    endfunction

    function automatic logic [NUM_CH*SAMPLE_W-1:0] m_samples();
        logic [NUM_CH*SAMPLE_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*SAMPLE_W +: SAMPLE_W] = m_s[k];
        return v;
    endfunction

    function automatic logic [31:0] mk_word(input int ch);
        logic [31:0] r;
        r = $urandom;
        return (r & 32'hFFFF_C000) | (32'(ch) << 10) | 32'($urandom_range(0, 1023));
    endfunction

    task automatic cs_low();
        spi.cs_n = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (half) @(negedge clk);
        spi.cs_n = 1'b1;
        repeat (3 * half) @(negedge clk);
        #1;
    endtask

    // Mode-0 master: data set while sck low, slave sdi sampled at the rise.
    task automatic spi_word(input logic [31:0] w, input int nbits,
                            output logic [31:0] got, output int lat);
        got = '0;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            spi.sdo = w[31-i];
            repeat (half) @(negedge clk);
            got     = {got[30:0], spi.sdi};
            spi.sck = 1'b1;
            for (int k = 1; k <= half; k++) begin
                @(negedge clk);
                if (rx_valid && lat == 0) lat = k;
            end
            spi.sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [31:0] w, input logic [31:0] exp_tx, input string tag);
        logic [31:0] got;
        int lat, exp_sv, b_rxv, b_sv, b_bad;
        b_rxv = n_rxv;
        b_sv  = n_sv;
        b_bad = n_bad;
        spi_word(w, 32, got, lat);
        #1;
        exp_sv = model_word(w);
        check({tag, ":sdi"},      64'(got),           64'(exp_tx));
        check({tag, ":rx_data"},  64'(rx_data),       64'(m_rx));
        check({tag, ":samples"},  64'(samples),       64'(m_samples()));
        check({tag, ":err_cnt"},  64'(err_cnt),       64'(m_err));
        check({tag, ":rx_valid"}, 64'(n_rxv - b_rxv), 64'(1));
        check({tag, ":latency"},  64'(lat),           64'(SYNC_STAGES + 2));
        if (exp_sv != 0) begin
            check({tag, ":sv_cnt"}, 64'(n_sv - b_sv), 64'(1));
            check({tag, ":sv_vec"}, 64'(sv_last),     64'(exp_sv));
        end else begin
            check({tag, ":sv_none"}, 64'(n_sv - b_sv),   64'(0));
            check({tag, ":bad_ch"},  64'(n_bad - b_bad), 64'(1));
        end
    endtask

    initial begin
        logic [31:0] t1, t2, t3, w, got;
        int b_txt, b_rxv, b_ferr, b_sv, b_bad, lat, nw, cnt;
        logic [31:0] wq [3];
        logic [31:0] tq [4];

        reset    = 1'b0;
        spi.sck  = 1'b0;
        spi.sdo  = 1'b0;
        spi.cs_n = 1'b1;
        tx_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset:pulses", 64'({rx_valid, tx_taken, sample_valid, frame_err, bad_ch, spi.sdi}), 64'(0));
        check("reset:rx_data", 64'(rx_data), 64'(0));
        check("reset:samples", 64'(samples), 64'(0));
        check("reset:err_cnt", 64'(err_cnt), 64'(0));
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // single word
        tx_data = 32'hA5A5_0001;
        b_txt = n_txt;
        cs_low();
        #1;
        check("single:tx_taken_start", 64'(n_txt - b_txt), 64'(1));
        xfer(32'h0000_0155, 32'hA5A5_0001, "single");
        cs_high();
        // word load plus the reload at end-of-word with cs_n still low
        check("single:tx_taken_total", 64'(n_txt - b_txt), 64'(2));

        // back-to-back words, tx_data changed between words
        t1 = $urandom; t2 = $urandom; t3 = $urandom;
        tx_data = t1;
        b_txt = n_txt;
        cs_low();
        tx_data = t2;
        xfer(32'h0000_07FF, t1, "b2b0");
        tx_data = t3;
        xfer(32'h0000_0C2A, t2, "b2b1");
        cs_high();
        check("b2b:tx_taken", 64'(n_txt - b_txt), 64'(3));

        // abort after 17 bits
        b_ferr = n_ferr;
        b_rxv  = n_rxv;
        tx_data = $urandom;
        cs_low();
        spi_word(mk_word(2), 17, got, lat);
        cs_high();
        if (m_err < 255) m_err++;
        check("abort:frame_err", 64'(n_ferr - b_ferr), 64'(1));
        check("abort:err_cnt",   64'(err_cnt),         64'(m_err));
        check("abort:rx_valid",  64'(n_rxv - b_rxv),   64'(0));
        check("abort:rx_data",   64'(rx_data),         64'(m_rx));
        check("abort:samples",   64'(samples),         64'(m_samples()));
        t1 = $urandom;
        tx_data = t1;
        cs_low();
        xfer(mk_word($urandom_range(0, 3)), t1, "recover");
        cs_high();

        // bad channel
        t1 = $urandom;
        tx_data = t1;
        cs_low();
        xfer(32'h0000_1001, t1, "badch");
        cs_high();

        // random frames of 1..3 words, channels 0..5
        for (int f = 0; f < 10; f++) begin
            nw = $urandom_range(1, 3);
            for (int j = 0; j <= nw; j++) tq[j] = $urandom;
            for (int j = 0; j < nw; j++) wq[j] = mk_word($urandom_range(0, 5));
            tx_data = tq[0];
            cs_low();
            for (int j = 0; j < nw; j++) begin
                tx_data = tq[j+1];
                xfer(wq[j], tq[j], $sformatf("rand%0d.%0d", f, j));
            end
            cs_high();
        end

        // sck/sdo activity with cs_n high must be ignored
        b_rxv = n_rxv; b_txt = n_txt; b_ferr = n_ferr; b_sv = n_sv; b_bad = n_bad;
        for (int i = 0; i < 20; i++) begin
            spi.sdo = 1'($urandom);
            spi.sck = 1'b1;
            repeat (half) @(negedge clk);
            spi.sck = 1'b0;
            repeat (half) @(negedge clk);
        end
        #1;
        check("noise:pulses",  64'((n_rxv - b_rxv) + (n_txt - b_txt) + (n_ferr - b_ferr)
                                   + (n_sv - b_sv) + (n_bad - b_bad)), 64'(0));
        check("noise:rx_data", 64'(rx_data), 64'(m_rx));
        check("noise:samples", 64'(samples), 64'(m_samples()));
        check("noise:err_cnt", 64'(err_cnt), 64'(m_err));
        check("noise:sdi",     64'(spi.sdi), 64'(0));

        // saturate err_cnt with bad-channel words in one long frame
        half  = 4;
        b_bad = n_bad;
        cnt   = (255 - m_err) + 5;
        tx_data = $urandom;
        cs_low();
        for (int i = 0; i < cnt; i++) begin
            w = mk_word($urandom_range(4, 15));
            spi_word(w, 32, got, lat);
            void'(model_word(w));
            if (m_err == 200) begin
                #1;
                check("sat:mid_count", 64'(err_cnt), 64'(m_err));
            end
        end
        cs_high();
        check("sat:err_cnt",  64'(err_cnt),       64'(255));
        check("sat:model",    64'(err_cnt),       64'(m_err));
        check("sat:bad_ch",   64'(n_bad - b_bad), 64'(cnt));
        check("sat:samples",  64'(samples),       64'(m_samples()));
        half = 5;

        // asynchronous reset in the middle of a word
        tx_data = $urandom;
        cs_low();
        spi_word(mk_word(1), 12, got, lat);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst:pulses",  64'({rx_valid, tx_taken, sample_valid, frame_err, bad_ch, spi.sdi}), 64'(0));
        check("arst:rx_data", 64'(rx_data), 64'(0));
        check("arst:samples", 64'(samples), 64'(0));
        check("arst:err_cnt", 64'(err_cnt), 64'(0));
        spi.cs_n = 1'b1;
        spi.sck  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        t1 = $urandom;
        tx_data = t1;
        cs_low();
        xfer(32'h0000_0201, t1, "post_reset");
        cs_high();
        check("post_reset:ch0", 64'(samples[SAMPLE_W-1:0]), 64'(10'h201));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
